// File: rtl/sliding_window_gen.sv
// Streaming KX x KY window generator: buffers KY-1 image rows and emits every
// window on a STRIDE grid with output coordinates and an end-of-frame flag.
module sliding_window_gen #(
  parameter int I_F_BW  = 8,
  parameter int CI      = 1,
  parameter int KX      = 5,
  parameter int KY      = 5,
  parameter int IX      = 28,
  parameter int IY      = 28,
  parameter int STRIDE  = 1,
  localparam int OX     = (IX - KX) / STRIDE + 1,
  localparam int OY     = (IY - KY) / STRIDE + 1,
  localparam int ROW_W  = (OY > 1) ? $clog2(OY) : 1,
  localparam int COL_W  = (OX > 1) ? $clog2(OX) : 1,
  localparam int PIX_W  = CI * I_F_BW,
  localparam int WIN_W  = KY * KX * PIX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [PIX_W-1:0] i_pixel,
  output logic             o_ready,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIN_W-1:0] o_window,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_last
);

  localparam int CW = (IX > 1) ? $clog2(IX) : 1;
  localparam int RW = (IY > 1) ? $clog2(IY) : 1;
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0]    COL_LAST  = CW'(IX - 1);
  localparam logic [CW-1:0]    COL_FIRST = CW'(KX - 1);
  localparam logic [RW-1:0]    ROW_LAST  = RW'(IY - 1);
  localparam logic [RW-1:0]    ROW_FIRST = RW'(KY - 1);
  localparam logic [PW-1:0]    PH_LAST   = PW'(STRIDE - 1);
  localparam logic [COL_W-1:0] OCOL_LAST = COL_W'(OX - 1);
  localparam logic [ROW_W-1:0] OROW_LAST = ROW_W'(OY - 1);

  logic [CW-1:0]    col_p0;
  logic [RW-1:0]    row_p0;
  logic [PW-1:0]    col_ph;
  logic [PW-1:0]    row_ph;
  logic [COL_W-1:0] ocol_cnt;
  logic [ROW_W-1:0] orow_cnt;

  logic [PIX_W-1:0] lb      [KY-1][IX];
  logic [PIX_W-1:0] win_p0  [KY][KX];
  logic [PIX_W-1:0] win_nxt [KY][KX];
  logic [WIN_W-1:0] win_flat;

  logic accept;
  logic emit;

  function automatic logic [PW-1:0] ph_step(input logic [PW-1:0] ph);
    return (ph == PH_LAST) ? '0 : ph + PW'(1);
  endfunction

  assign o_ready = !reset && (!o_valid || i_ready);
  assign accept  = i_valid && o_ready;
  assign emit    = (row_p0 >= ROW_FIRST) && (col_p0 >= COL_FIRST) &&
                   (row_ph == '0) && (col_ph == '0);

  // Next window: shift left one column, new column from line buffer + pixel
  always_comb begin
    for (int r = 0; r < KY; r++) begin
      for (int c = 0; c < KX - 1; c++) begin
        win_nxt[r][c] = win_p0[r][c+1];
      end
    end
    for (int r = 0; r < KY - 1; r++) begin
      win_nxt[r][KX-1] = lb[r][col_p0];
    end
    win_nxt[KY-1][KX-1] = i_pixel;
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < KY; r++) begin
      for (int c = 0; c < KX; c++) begin
        win_flat[(r*KX + c)*PIX_W +: PIX_W] = win_nxt[r][c];
      end
    end
  end

  // Stage p0: line buffer and window register, data only
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < KY - 2; k++) begin
        lb[k][col_p0] <= lb[k+1][col_p0];
      end
      lb[KY-2][col_p0] <= i_pixel;
      win_p0 <= win_nxt;
    end
  end

  // Input raster counters and stride phases
  always_ff @(posedge clk) begin
    if (reset) begin
      col_p0 <= '0;
      row_p0 <= '0;
      col_ph <= '0;
      row_ph <= '0;
    end else if (accept) begin
      if (col_p0 == COL_LAST) begin
        col_p0 <= '0;
        col_ph <= '0;
        if (row_p0 == ROW_LAST) begin
          row_p0 <= '0;
          row_ph <= '0;
        end else begin
          row_p0 <= row_p0 + RW'(1);
          row_ph <= (row_p0 < ROW_FIRST) ? '0 : ph_step(row_ph);
        end
      end else begin
        col_p0 <= col_p0 + CW'(1);
        col_ph <= (col_p0 < COL_FIRST) ? '0 : ph_step(col_ph);
      end
    end
  end

  // Stage p1: single output slot with coordinates
  always_ff @(posedge clk) begin
    if (reset) begin
      ocol_cnt <= '0;
      orow_cnt <= '0;
      o_valid  <= 1'b0;
      o_window <= '0;
      o_row    <= '0;
      o_col    <= '0;
      o_last   <= 1'b0;
    end else if (accept && emit) begin
      o_valid  <= 1'b1;
      o_window <= win_flat;
      o_row    <= orow_cnt;
      o_col    <= ocol_cnt;
      o_last   <= (orow_cnt == OROW_LAST) && (ocol_cnt == OCOL_LAST);
      if (ocol_cnt == OCOL_LAST) begin
        ocol_cnt <= '0;
        orow_cnt <= (orow_cnt == OROW_LAST) ? '0 : orow_cnt + ROW_W'(1);
      end else begin
        ocol_cnt <= ocol_cnt + COL_W'(1);
      end
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sliding_window_gen.sv
// Bench for sliding_window_gen: a default 5x5 instance and a 3-channel stride-2
// instance, ramp-image stimulus, queue scoreboard checked by per-DUT monitors.
module tb_sliding_window_gen;

  typedef struct {
    logic [599:0] win;
    int           row;
    int           col;
    logic         last;
    int           due;
    bit           strict;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         a_ivalid, a_iready, a_oready, a_ovalid, a_olast;
  logic [7:0]   a_pixel;
  logic [199:0] a_owin;
  logic [4:0]   a_orow, a_ocol;
  logic         b_ivalid, b_iready, b_oready, b_ovalid, b_olast;
  logic [23:0]  b_pixel;
  logic [599:0] b_owin;
  logic [3:0]   b_orow, b_ocol;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   a_cnt = 0;
  int   b_cnt = 0;
  bit   a_rand = 0;

  sliding_window_gen dut_a (
    .clk(clk), .reset(reset), .i_valid(a_ivalid), .i_pixel(a_pixel),
    .o_ready(a_oready), .i_ready(a_iready), .o_valid(a_ovalid),
    .o_window(a_owin), .o_row(a_orow), .o_col(a_ocol), .o_last(a_olast)
  );

  sliding_window_gen #(.CI(3), .STRIDE(2)) dut_b (
    .clk(clk), .reset(reset), .i_valid(b_ivalid), .i_pixel(b_pixel),
    .o_ready(b_oready), .i_ready(b_iready), .o_valid(b_ovalid),
    .o_window(b_owin), .o_row(b_orow), .o_col(b_ocol), .o_last(b_olast)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cyc > 60000) begin
      $display("FAIL watchdog: cycle %0d exceeds budget 60000", cyc);
      $fatal(1, "watchdog");
    end
  end

  always @(posedge clk) begin
    #1;
    if (a_rand) a_iready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [599:0] got, input logic [599:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic int ramp(input int r, input int c, input int off);
    return (r*28 + c + off) % 256;
  endfunction

  function automatic logic [599:0] exp_win(input int ci, input int s, input int off,
                                           input int oy, input int ox);
    logic [599:0] w;
    int p;
    w = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        p = ramp(oy*s + r, ox*s + c, off);
        for (int ch = 0; ch < ci; ch++) begin
          w[((r*5 + c)*ci + ch)*8 +: 8] = 8'((p + ch) % 256);
        end
      end
    end
    return w;
  endfunction

  function automatic bit emits(input int r, input int c, input int s);
    return (r >= 4) && (c >= 4) && ((r - 4) % s == 0) && ((c - 4) % s == 0);
  endfunction

  function automatic exp_t make_exp(input int r, input int c, input int off, input int ci,
                                    input int s, input bit strict);
    exp_t e;
    int n;
    n = 23 / s + 1;
    e.row = (r - 4) / s;
    e.col = (c - 4) / s;
    e.last = (e.row == n - 1) && (e.col == n - 1);
    e.win = exp_win(ci, s, off, e.row, e.col);
    e.due = cyc + 1;
    e.strict = strict;
    return e;
  endfunction

  task automatic send_a(input int r, input int c, input int off, input bit gaps, input bit strict);
    bit done;
    done = 0;
    while (!done) begin
      a_ivalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      a_pixel = a_ivalid ? 8'(ramp(r, c, off)) : 8'($urandom);
      @(negedge clk);
      if (a_ivalid && a_oready) begin
        done = 1;
        if (emits(r, c, 1)) qa.push_back(make_exp(r, c, off, 1, 1, strict));
      end
      @(posedge clk);
      #1;
    end
    a_ivalid = 1'b0;
  endtask

  task automatic send_b(input int r, input int c, input int off);
    bit done;
    int p;
    done = 0;
    p = ramp(r, c, off);
    while (!done) begin
      b_ivalid = 1'b1;
      b_pixel = {8'((p + 2) % 256), 8'((p + 1) % 256), 8'(p)};
      @(negedge clk);
      if (b_oready) begin
        done = 1;
        if (emits(r, c, 2)) qb.push_back(make_exp(r, c, off, 3, 2, 1'b1));
      end
      @(posedge clk);
      #1;
    end
    b_ivalid = 1'b0;
  endtask

  task automatic frame_a(input int off, input bit gaps, input int npix, input bit strict);
    for (int i = 0; i < npix; i++) send_a(i / 28, i % 28, off, gaps, strict);
  endtask

  task automatic frame_b(input int off);
    for (int i = 0; i < 784; i++) send_b(i / 28, i % 28, off);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || a_ovalid || b_ovalid) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain: %0d/%0d windows still pending after %0d cycles", qa.size(), qb.size(), n);
    end
  endtask

  // Monitor A: scoreboard pop, latency, stall stability and o_ready rule
  bit           a_seen = 0;
  bit           a_hold_v = 0;
  logic [199:0] a_hold_w;
  logic [4:0]   a_hold_r, a_hold_c;
  always begin
    exp_t e;
    @(negedge clk);
    check("a_o_ready", 600'(a_oready), 600'(!reset && !(a_ovalid && !a_iready)));
    if (a_hold_v) begin
      check("a_stall_valid", 600'(a_ovalid), 600'(a_hold_v));
      check("a_stall_window", 600'(a_owin), 600'(a_hold_w));
      check("a_stall_coord", 600'({a_orow, a_ocol}), 600'({a_hold_r, a_hold_c}));
    end
    if (a_ovalid && !a_seen) begin
      a_seen = 1;
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: window at row %0d col %0d, expected none", a_orow, a_ocol);
      end else begin
        e = qa.pop_front();
        a_cnt++;
        check("a_window", 600'(a_owin), e.win);
        check("a_row", 600'(a_orow), 600'(e.row));
        check("a_col", 600'(a_ocol), 600'(e.col));
        check("a_last", 600'(a_olast), 600'(e.last));
        if (e.strict) check("a_latency", 600'(cyc), 600'(e.due));
      end
    end
    if (!a_ovalid || a_iready) a_seen = 0;
    a_hold_v = !reset && a_ovalid && !a_iready;
    a_hold_w = a_owin;
    a_hold_r = a_orow;
    a_hold_c = a_ocol;
  end

  // Monitor B
  bit b_seen = 0;
  always begin
    exp_t e;
    @(negedge clk);
    check("b_o_ready", 600'(b_oready), 600'(!reset && !(b_ovalid && !b_iready)));
    if (b_ovalid && !b_seen) begin
      b_seen = 1;
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: window at row %0d col %0d, expected none", b_orow, b_ocol);
      end else begin
        e = qb.pop_front();
        b_cnt++;
        check("b_window", b_owin, e.win);
        check("b_row", 600'(b_orow), 600'(e.row));
        check("b_col", 600'(b_ocol), 600'(e.col));
        check("b_last", 600'(b_olast), 600'(e.last));
        check("b_latency", 600'(cyc), 600'(e.due));
      end
    end
    if (!b_ovalid || b_iready) b_seen = 0;
  end

  initial begin
    reset = 1'b1;
    a_ivalid = 1'b0; a_pixel = '0; a_iready = 1'b1;
    b_ivalid = 1'b0; b_pixel = '0; b_iready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_valid", 600'(a_ovalid), 600'(0));
    check("rst_a_window", 600'(a_owin), 600'(0));
    check("rst_a_coord", 600'({a_orow, a_ocol, a_olast}), 600'(0));
    check("rst_a_ready", 600'(a_oready), 600'(0));
    check("rst_b_valid", 600'(b_ovalid), 600'(0));
    check("rst_b_window", b_owin, 600'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Back-to-back frames on A (offset 0 then 100); stride-2 RGB frame on B
    fork
      begin
        frame_a(0, 1'b0, 784, 1'b1);
        frame_a(100, 1'b0, 784, 1'b1);
      end
      frame_b(0);
    join
    drain(200);
    check("a_count_two_frames", 600'(a_cnt), 600'(1152));
    check("b_count_stride2", 600'(b_cnt), 600'(144));

    // Random downstream stalls and input gaps
    a_cnt = 0;
    a_rand = 1;
    frame_a(7, 1'b1, 784, 1'b0);
    drain(3000);
    a_rand = 0;
    @(posedge clk);
    #1;
    a_iready = 1'b1;
    check("a_count_random", 600'(a_cnt), 600'(576));

    // Reset one cycle after pixel (10,10), then a fresh frame
    a_cnt = 0;
    frame_a(0, 1'b0, 10*28 + 11, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_valid", 600'(a_ovalid), 600'(0));
    check("midrst_coord", 600'({a_orow, a_ocol, a_olast}), 600'(0));
    check("a_count_partial", 600'(a_cnt), 600'(151));
    @(posedge clk);
    #1;
    a_cnt = 0;
    frame_a(50, 1'b0, 784, 1'b1);
    drain(200);
    check("a_count_after_reset", 600'(a_cnt), 600'(576));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
